// File: rtl/sort_arbiter.sv
// Two-client round-robin front end for a shared 8-bit signed sorter: buffer, burst, collect.
// Optional collect watchdog enabled by defining SORT_ARB_TIMEOUT_EN.
module sort_arbiter #(
    parameter int BATCH    = 8,
    parameter int MAX_IDLE = 10
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              req0,
    input  logic              req1,
    input  logic signed [7:0] data0,
    input  logic signed [7:0] data1,
    input  logic              valid0,
    input  logic              valid1,
    output logic              gnt0,
    output logic              gnt1,
    output logic signed [7:0] s_in1,
    output logic              s_in2,
    input  logic signed [7:0] s_mout1,
    input  logic              s_mout2,
    output logic signed [7:0] res_data,
    output logic              res_valid0,
    output logic              res_valid1,
    output logic              busy,
    output logic              timeout_err
);
    localparam int CW = $clog2(BATCH);

    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, GAP, COLLECT} state_t;

    state_t            state, nstate;
    logic [CW-1:0]     cnt;
    logic              owner, last_gnt;
    logic signed [7:0] mem [BATCH];
    logic              pick, cap, last_el, res_take, tmo;

    // Tie goes to the client not served last; a lone requester always wins.
    assign pick     = (req0 && req1) ? ~last_gnt : req1;
    assign cap      = (state == LOAD) && (owner ? (valid1 && gnt1) : (valid0 && gnt0));
    assign last_el  = (cnt == CW'(BATCH - 1));
    assign res_take = (state == COLLECT) && s_mout2;

    assign busy  = (state != IDLE);
    assign s_in2 = (state == ISSUE);
    assign s_in1 = (state == ISSUE) ? mem[cnt] : '0;

`ifdef SORT_ARB_TIMEOUT_EN
    localparam int IW = $clog2(MAX_IDLE + 1);
    logic [IW-1:0] idle_cnt;

    // Idle cycles accumulate across the whole collect phase, valid results do not clear it.
    assign tmo = (state == COLLECT) && !s_mout2 && (idle_cnt == IW'(MAX_IDLE));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            idle_cnt    <= '0;
            timeout_err <= 1'b0;
        end else if (state != COLLECT) begin
            idle_cnt <= '0;
        end else if (!s_mout2) begin
            idle_cnt <= idle_cnt + 1'b1;
            if (tmo) timeout_err <= 1'b1;
        end
    end
`else
    assign tmo         = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (req0 || req1) nstate = LOAD;
            LOAD:    if (cap && last_el) nstate = ISSUE;
            ISSUE:   if (last_el) nstate = GAP;
            GAP:     nstate = COLLECT;
            COLLECT: if ((res_take && last_el) || tmo) nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt        <= '0;
            owner      <= 1'b0;
            last_gnt   <= 1'b1;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            res_data   <= '0;
            res_valid0 <= 1'b0;
            res_valid1 <= 1'b0;
        end else begin
            res_valid0 <= res_take && !owner;
            res_valid1 <= res_take && owner;
            if (res_take) res_data <= s_mout1;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (req0 || req1) begin
                        owner <= pick;
                        gnt0  <= ~pick;
                        gnt1  <= pick;
                    end
                end
                LOAD: begin
                    // cnt wraps to 0 on the last capture, ready to index the issue burst.
                    if (cap) begin
                        cnt <= cnt + 1'b1;
                        if (last_el) begin
                            gnt0 <= 1'b0;
                            gnt1 <= 1'b0;
                        end
                    end
                end
                ISSUE: cnt <= cnt + 1'b1;
                COLLECT: begin
                    if (res_take) cnt <= cnt + 1'b1;
                    if ((res_take && last_el) || tmo) last_gnt <= owner;
                end
                default: ;
            endcase
        end
    end

    // Batch buffer carries no reset; stale contents are never issued.
    always_ff @(posedge CLK) begin
        if (cap) mem[cnt] <= owner ? data1 : data0;
    end
endmodule

// File: tb/tb_sort_arbiter.sv
// Bench for sort_arbiter: random batches checked against a sort-based reference and round-robin model.
module tb_sort_arbiter;
    logic       CLK = 1'b0, RESET = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0, valid0 = 1'b0, valid1 = 1'b0, s_mout2 = 1'b0;
    logic [7:0] data0 = '0, data1 = '0, s_mout1 = '0;
    logic       gnt0, gnt1, s_in2, res_valid0, res_valid1, busy, timeout_err;
    logic [7:0] s_in1, res_data;

    typedef logic [7:0] batch_t [8];

    int errors = 0, checks = 0;
    int exp_last = 1;

    sort_arbiter dut (
        .CLK(CLK), .RESET(RESET), .req0(req0), .req1(req1),
        .data0(data0), .data1(data1), .valid0(valid0), .valid1(valid1),
        .gnt0(gnt0), .gnt1(gnt1), .s_in1(s_in1), .s_in2(s_in2),
        .s_mout1(s_mout1), .s_mout2(s_mout2), .res_data(res_data),
        .res_valid0(res_valid0), .res_valid1(res_valid1),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic batch_t sort_b(input batch_t d);
        batch_t s;
        logic [7:0] t;
        s = d;
        for (int i = 1; i < 8; i++)
            for (int j = i; j > 0; j--)
                if ($signed(s[j]) < $signed(s[j-1])) begin
                    t = s[j]; s[j] = s[j-1]; s[j-1] = t;
                end
        return s;
    endfunction

    function automatic batch_t rand_b();
        batch_t d;
        for (int i = 0; i < 8; i++) d[i] = 8'($urandom);
        return d;
    endfunction

    task automatic request(input logic a0, input logic a1, output int win, output int waited);
        if (a0 && a1) win = (exp_last == 0) ? 1 : 0;
        else          win = a1 ? 1 : 0;
        req0 = a0; req1 = a1; waited = 0;
        do begin tick(); waited++; end while (!(gnt0 || gnt1) && waited < 20);
        checks++;
        if ({gnt1, gnt0} !== ((win == 1) ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL grant: gnt1,gnt0=%b%b expected client %0d", gnt1, gnt0, win);
        end
        if (win == 1) req1 = 1'b0; else req0 = 1'b0;
    endtask

    task automatic load_issue(input int cl, input batch_t d, input int maxgap, input bit noise);
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(maxgap, 0)) begin
                if (cl == 0) valid0 = 1'b0; else valid1 = 1'b0;
                if (noise) begin
                    if (cl == 0) begin valid1 = 1'b1; data1 = 8'($urandom); end
                    else         begin valid0 = 1'b1; data0 = 8'($urandom); end
                end
                s_mout2 = 1'($urandom); s_mout1 = 8'($urandom);
                tick();
                checks++;
                if (s_in2 !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL load_gap: s_in2=%b busy=%b expected 0/1", s_in2, busy);
                end
            end
            if (cl == 0) begin valid0 = 1'b1; data0 = d[i]; if (noise) begin valid1 = 1'b1; data1 = 8'($urandom); end end
            else         begin valid1 = 1'b1; data1 = d[i]; if (noise) begin valid0 = 1'b1; data0 = 8'($urandom); end end
            tick();
        end
        valid0 = 1'b0; valid1 = 1'b0;
        checks++;
        if ({gnt0, gnt1} !== 2'b00) begin
            errors++;
            $display("FAIL gnt_drop: gnt0,gnt1=%b%b expected 00", gnt0, gnt1);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (s_in2 !== 1'b1 || s_in1 !== d[k]) begin
                errors++;
                $display("FAIL issue[%0d]: s_in2=%b s_in1=%h expected 1/%h", k, s_in2, s_in1, d[k]);
            end
            s_mout2 = 1'($urandom); s_mout1 = 8'($urandom);
            tick();
        end
        checks++;
        if (s_in2 !== 1'b0 || s_in1 !== 8'h00 || busy !== 1'b1) begin
            errors++;
            $display("FAIL gap: s_in2=%b s_in1=%h busy=%b expected 0/00/1", s_in2, s_in1, busy);
        end
        s_mout2 = 1'b1; s_mout1 = 8'($urandom);
        tick();
        s_mout2 = 1'b0;
        checks++;
        if (res_valid0 !== 1'b0 || res_valid1 !== 1'b0 || s_in2 !== 1'b0) begin
            errors++;
            $display("FAIL collect_entry: res_valid=%b%b s_in2=%b expected 00/0", res_valid1, res_valid0, s_in2);
        end
    endtask

    task automatic collect(input int cl, input batch_t d, input int n, input int maxgap);
        batch_t s;
        s = sort_b(d);
        for (int j = 0; j < n; j++) begin
            repeat ($urandom_range(maxgap, 0)) begin
                s_mout2 = 1'b0; s_mout1 = 8'($urandom);
                tick();
                checks++;
                if (res_valid0 !== 1'b0 || res_valid1 !== 1'b0) begin
                    errors++;
                    $display("FAIL res_idle: res_valid1,0=%b%b expected 00", res_valid1, res_valid0);
                end
            end
            s_mout2 = 1'b1; s_mout1 = s[j];
            tick();
            checks++;
            if (res_data !== s[j] || res_valid0 !== (cl == 0) || res_valid1 !== (cl == 1)) begin
                errors++;
                $display("FAIL result[%0d]: data=%h rv1,rv0=%b%b expected %h for client %0d",
                         j, res_data, res_valid1, res_valid0, s[j], cl);
            end
        end
        s_mout2 = 1'b0;
        if (n == 8) begin
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL done_idle: busy=%b expected 0", busy);
            end
            exp_last = cl;
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        exp_last = 1;
    endtask

    task automatic test_reset();
        tick(); tick();
        checks++;
        if ({gnt0, gnt1, s_in1, s_in2, res_data, res_valid0, res_valid1, busy, timeout_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: gnt=%b%b s_in=%h/%b res=%h/%b%b busy=%b to=%b expected all 0",
                     gnt0, gnt1, s_in1, s_in2, res_data, res_valid0, res_valid1, busy, timeout_err);
        end
        RESET = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        int win, w;
        batch_t d;
        request(1'b1, 1'b0, win, w);
        for (int i = 0; i < 3; i++) begin valid0 = 1'b1; data0 = 8'($urandom); tick(); end
        #2 RESET = 1'b1;
        #1;
        checks++;
        if ({gnt0, gnt1, s_in1, s_in2, res_data, res_valid0, res_valid1, busy, timeout_err} !== '0) begin
            errors++;
            $display("FAIL reset_mid_load: gnt0=%b busy=%b expected all outputs 0", gnt0, busy);
        end
        valid0 = 1'b0;
        tick();
        RESET = 1'b0;
        exp_last = 1;
        d = rand_b();
        request(1'b1, 1'b0, win, w);
        load_issue(0, d, 0, 1'b0);
        collect(0, d, 8, 0);
    endtask

    task automatic test_directed();
        int win, w;
        batch_t d;
        d = '{8'h7F, 8'h80, 8'h00, 8'hFF, 8'h01, 8'h05, 8'hFE, 8'h10};
        request(1'b1, 1'b0, win, w);
        load_issue(0, d, 0, 1'b0);
        collect(0, d, 8, 0);
    endtask

    task automatic test_round_robin();
        int win, w;
        batch_t d;
        do_reset();
        d = rand_b();
        request(1'b1, 1'b1, win, w);
        load_issue(win, d, 0, 1'b0);
        collect(win, d, 8, 0);
        checks++;
        if (gnt1 !== 1'b0) begin
            errors++;
            $display("FAIL mandatory_idle: gnt1=%b expected 0", gnt1);
        end
        d = rand_b();
        request(1'b0, 1'b1, win, w);
        checks++;
        if (w !== 1) begin
            errors++;
            $display("FAIL next_grant_latency: waited=%0d expected 1", w);
        end
        load_issue(win, d, 0, 1'b0);
        collect(win, d, 8, 0);
        d = rand_b();
        request(1'b1, 1'b1, win, w);
        load_issue(win, d, 1, 1'b0);
        collect(win, d, 8, 1);
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_gaps_noise();
        int win, w;
        batch_t d;
        d = rand_b();
        request(1'b0, 1'b1, win, w);
        load_issue(1, d, 3, 1'b1);
        collect(1, d, 8, 1);
    endtask

    task automatic test_random();
        int win, w, a;
        batch_t d;
        for (int it = 0; it < 8; it++) begin
            a = $urandom_range(3, 1);
            d = rand_b();
            request(a[0], a[1], win, w);
            load_issue(win, d, $urandom_range(2, 0), 1'b1);
            collect(win, d, 8, 1);
            req0 = 1'b0; req1 = 1'b0;
        end
    endtask

    task automatic test_timeout();
        int win, w;
        batch_t d;
        d = rand_b();
        request(1'b1, 1'b0, win, w);
        load_issue(0, d, 0, 1'b0);
        collect(0, d, 4, 0);
        s_mout2 = 1'b0;
`ifdef SORT_ARB_TIMEOUT_EN
        repeat (10) tick();
        checks++;
        if (busy !== 1'b1 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: busy=%b timeout_err=%b expected 1/0", busy, timeout_err);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || timeout_err !== 1'b1 || res_valid0 !== 1'b0) begin
            errors++;
            $display("FAIL timeout_fire: busy=%b timeout_err=%b rv0=%b expected 0/1/0", busy, timeout_err, res_valid0);
        end
        exp_last = 0;
        request(1'b1, 1'b0, win, w);
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: timeout_err=%b expected 1", timeout_err);
        end
`else
        repeat (30) tick();
        checks++;
        if (busy !== 1'b1 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL stall_wait: busy=%b timeout_err=%b expected 1/0", busy, timeout_err);
        end
`endif
        do_reset();
    endtask

    initial begin
        test_reset();
        test_reset_mid_load();
        test_directed();
        test_round_robin();
        test_gaps_noise();
        test_random();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
